// File: rtl/galaksija_load_ctrl_pkg.sv
// Shared definitions for the Galaksija download loader.
// Holds the loader FSM state encoding, the default load window and a
// helper that forms the 17-bit RAM target (bit 16 flags a wrapped sum).
package galaksija_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [15:0] LOAD_BASE_DEFAULT = 16'h2000;
    localparam logic [15:0] RAM_TOP_DEFAULT   = 16'h3FFF;
    localparam int          ENTRY_W           = 24;

    // Base + offset with the carry kept so a 16-bit wrap can be detected.
    function automatic logic [16:0] target_addr(input logic [15:0] base,
                                                input logic [15:0] offs);
        return {1'b0, base} + {1'b0, offs};
    endfunction

endpackage

// File: rtl/galaksija_load_ctrl_fifo.sv
// load_fifo: small synchronous FIFO buffering download entries.
// Ports: clk_i/reset_i (sync, active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head entry), count_o
// occupancy, full_o/empty_o flags. Push and pop may occur together.
module load_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Pointer and occupancy tracking; simultaneous push/pop keeps the count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/galaksija_load_ctrl.sv
// galaksija_load_ctrl: arbitrates the shared RAM port between the Z80 and
// the HPS download stream. While a download runs the CPU is parked on
// WAIT, incoming bytes are buffered and written at LOAD_BASE+offset.
// Ports: clk_sys/reset (sync, active-high); ioctl_* download stream with
// ioctl_wait backpressure; cpu_ram_* CPU request channel and cpu_wait_n;
// ram_addr/ram_din/ram_we shared RAM port; load_done pulse and sticky
// load_error.
module galaksija_load_ctrl
    import galaksija_load_ctrl_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE  = LOAD_BASE_DEFAULT,
    parameter logic [15:0] RAM_TOP    = RAM_TOP_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        cpu_ram_req,
    input  logic        cpu_ram_we,
    input  logic [15:0] cpu_ram_addr,
    input  logic [7:0]  cpu_ram_din,
    output logic        cpu_ram_ack,
    output logic        cpu_wait_n,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        load_done,
    output logic        load_error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic                dl_prev_q;
    logic                dl_rise_s;
    logic [16:0]         target_s;
    logic                in_range_s;
    logic                wr_seen_s;
    logic                fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_rdata_s;
    logic [CW-1:0]       fifo_count_s;
    logic [15:0]         ram_addr_q, ram_addr_d;
    logic [7:0]          ram_din_q, ram_din_d;
    logic                ram_we_q, ram_we_d;
    logic                ack_q, ack_d;
    logic                wait_n_q, wait_n_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    assign dl_rise_s  = ioctl_download && !dl_prev_q;
    assign target_s   = target_addr(LOAD_BASE, ioctl_addr[15:0]);
    assign in_range_s = (ioctl_addr[26:16] == 11'd0) && !target_s[16] &&
                        (target_s[15:0] <= RAM_TOP);
    // Bytes count only while a download session owns the FIFO; the rising
    // edge cycle itself is included so byte 0 is never lost.
    assign wr_seen_s  = ioctl_download && ioctl_wr &&
                        (((state_q == ST_IDLE) && dl_rise_s) ||
                         (state_q == ST_HOLD) || (state_q == ST_LOAD) ||
                         (state_q == ST_FLUSH));
    assign fifo_push_s = wr_seen_s && in_range_s && !fifo_full_s;
    assign fifo_pop_s  = ((state_q == ST_LOAD) || (state_q == ST_FLUSH)) &&
                         !fifo_empty_s;

    load_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk_i   (clk_sys),
        .reset_i (reset),
        .push_i  (fifo_push_s),
        .wdata_i ({target_s[15:0], ioctl_dout}),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state logic for the loader FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (dl_rise_s)       state_d = ST_HOLD;  else state_d = ST_IDLE;
            ST_HOLD:  if (!cpu_ram_req)    state_d = ST_LOAD;  else state_d = ST_HOLD;
            ST_LOAD:  if (!ioctl_download) state_d = ST_FLUSH; else state_d = ST_LOAD;
            ST_FLUSH: if (fifo_empty_s)    state_d = ST_DONE;  else state_d = ST_FLUSH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM port mux and status outputs; the loader owns the port outside IDLE.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        ack_d      = (state_q == ST_IDLE) && cpu_ram_req;
        wait_n_d   = (state_d == ST_IDLE);
        done_d     = (state_d == ST_DONE);
        if (fifo_pop_s) begin
            ram_addr_d = fifo_rdata_s[23:8];
            ram_din_d  = fifo_rdata_s[7:0];
            ram_we_d   = 1'b1;
        end else if ((state_q == ST_IDLE) && cpu_ram_req) begin
            ram_addr_d = cpu_ram_addr;
            ram_din_d  = cpu_ram_din;
            ram_we_d   = cpu_ram_we;
        end else begin
            ram_we_d   = 1'b0;
        end
        // A bad byte in the session's first cycle must still be reported.
        if (wr_seen_s && (!in_range_s || fifo_full_s)) begin
            error_d = 1'b1;
        end else if ((state_q == ST_IDLE) && dl_rise_s) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dl_prev_q  <= 1'b0;
            ram_addr_q <= 16'h0000;
            ram_din_q  <= 8'h00;
            ram_we_q   <= 1'b0;
            ack_q      <= 1'b0;
            wait_n_q   <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_prev_q  <= ioctl_download;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            ack_q      <= ack_d;
            wait_n_q   <= wait_n_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ioctl_wait  = (fifo_count_s >= CW'(FIFO_DEPTH - 1));
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_we      = ram_we_q;
    assign cpu_ram_ack = ack_q;
    assign cpu_wait_n  = wait_n_q;
    assign load_done   = done_q;
    assign load_error  = error_q;

endmodule

// File: tb/tb_galaksija_load_ctrl.sv
// Directed bench for galaksija_load_ctrl with a RAM-write scoreboard.
module tb_galaksija_load_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = 27'd0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic        cpu_ram_req = 1'b0;
    logic        cpu_ram_we = 1'b0;
    logic [15:0] cpu_ram_addr = 16'h0000;
    logic [7:0]  cpu_ram_din = 8'h00;
    logic        cpu_ram_ack;
    logic        cpu_wait_n;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        load_done;
    logic        load_error;

    int n_assert = 0;
    int n_fail   = 0;
    logic [23:0] exp_q [$];

    galaksija_load_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_ram_req(cpu_ram_req), .cpu_ram_we(cpu_ram_we),
        .cpu_ram_addr(cpu_ram_addr), .cpu_ram_din(cpu_ram_din),
        .cpu_ram_ack(cpu_ram_ack), .cpu_wait_n(cpu_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample #1 later, and score any RAM write.
    task automatic tick();
        logic [23:0] e;
        @(posedge clk_sys);
        #1;
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ram_we", ram_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("ram_write", {ram_addr, ram_din}, e);
            end
        end
    endtask

    task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
    endtask

    // Run until load_done (bounded), checking the CPU stays parked meanwhile.
    task automatic wait_done(input int budget);
        int dones = 0;
        int i = 0;
        while (dones == 0 && i < budget) begin
            tick();
            i++;
            if (load_done === 1'b1) dones++;
            else chk("wait_n_low", cpu_wait_n, 1'b0);
        end
        chk("load_done_seen", dones, 1);
        tick();
        chk("load_done_single", load_done, 1'b0);
        chk("wait_n_release", cpu_wait_n, 1'b1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_wait_n", cpu_wait_n, 1'b1);
        chk("rst_ioctl_wait", ioctl_wait, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_ram_din", ram_din, 8'h00);
        chk("rst_ack", cpu_ram_ack, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_error", load_error, 1'b0);
        reset = 1'b0;
        tick();

        // CPU write in IDLE
        cpu_ram_req = 1'b1; cpu_ram_we = 1'b1;
        cpu_ram_addr = 16'h2345; cpu_ram_din = 8'h5A;
        exp_q.push_back({16'h2345, 8'h5A});
        tick();
        chk("cpu_ack", cpu_ram_ack, 1'b1);
        chk("cpu_write_addr", ram_addr, 16'h2345);
        cpu_ram_req = 1'b0; cpu_ram_we = 1'b0;
        tick();
        chk("cpu_ack_pulse", cpu_ram_ack, 1'b0);
        chk("cpu_we_drop", ram_we, 1'b0);

        // Three-byte download
        ioctl_download = 1'b1;
        wr_byte(27'd0, 8'hA1); exp_q.push_back({16'h2000, 8'hA1}); tick();
        chk("dl_wait_n_0", cpu_wait_n, 1'b0);
        wr_byte(27'd1, 8'hB2); exp_q.push_back({16'h2001, 8'hB2}); tick();
        wr_byte(27'd2, 8'hC3); exp_q.push_back({16'h2002, 8'hC3}); tick();
        chk("dl_wait_n_2", cpu_wait_n, 1'b0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        wait_done(20);
        chk("dl_error_clear", load_error, 1'b0);

        // Download starts while the CPU holds a read request for two cycles
        cpu_ram_req = 1'b1; cpu_ram_we = 1'b0; cpu_ram_addr = 16'h1234;
        ioctl_download = 1'b1;
        wr_byte(27'd5, 8'h77); exp_q.push_back({16'h2005, 8'h77}); tick();
        chk("hold_cpu_ack", cpu_ram_ack, 1'b1);
        chk("hold_no_we_0", ram_we, 1'b0);
        ioctl_wr = 1'b0; tick();
        chk("hold_no_ack", cpu_ram_ack, 1'b0);
        chk("hold_no_we_1", ram_we, 1'b0);
        cpu_ram_req = 1'b0; tick();
        chk("hold_no_we_2", ram_we, 1'b0);
        ioctl_download = 1'b0;
        wait_done(20);

        // FIFO fill while stalled in HOLD; 5th write is dropped
        cpu_ram_req = 1'b1;
        ioctl_download = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_byte(27'h10 + 27'(k), 8'(k + 1));
            if (k < 4) exp_q.push_back({16'h2010 + 16'(k), 8'(k + 1)});
            tick();
            chk("fill_ioctl_wait", ioctl_wait, (k >= 2) ? 1'b1 : 1'b0);
            chk("fill_no_we", ram_we, 1'b0);
        end
        chk("fill_error", load_error, 1'b1);
        ioctl_wr = 1'b0; cpu_ram_req = 1'b0; ioctl_download = 1'b0;
        wait_done(20);
        chk("fill_error_sticky", load_error, 1'b1);

        // Out-of-range targets: above RAM_TOP and upper address bits set
        ioctl_download = 1'b1;
        wr_byte(27'h2000, 8'h55); tick();
        chk("oor_error", load_error, 1'b1);
        wr_byte(27'h0010000, 8'h66); tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        wait_done(20);
        chk("oor_error_kept", load_error, 1'b1);

        // Writes without an active download are ignored
        wr_byte(27'd3, 8'h99); tick(); tick();
        ioctl_wr = 1'b0;
        chk("nodl_ioctl_wait", ioctl_wait, 1'b0);
        chk("nodl_error", load_error, 1'b1);

        // Reset mid-LOAD with two bytes buffered
        ioctl_download = 1'b1;
        wr_byte(27'h20, 8'h11); exp_q.push_back({16'h2020, 8'h11}); tick();
        wr_byte(27'h21, 8'h22); tick();
        wr_byte(27'h22, 8'h33); tick();
        chk("mid_count", dut.u_fifo.count_o, 2);
        ioctl_wr = 1'b0; ioctl_download = 1'b0; reset = 1'b1;
        tick();
        chk("rst_mid_we", ram_we, 1'b0);
        chk("rst_mid_wait_n", cpu_wait_n, 1'b1);
        chk("rst_mid_empty", dut.u_fifo.empty_o, 1'b1);
        chk("rst_mid_error", load_error, 1'b0);
        reset = 1'b0;
        repeat (4) tick();
        chk("rst_mid_sb", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
